mem_bus_master: RTL and testbench

Burst initiator for the shared-bus scratchpad `mem` in the near-memory CNN accelerator.
- Accepts a command: direction, base address, beat count.
- Write: streams write-stream words onto the bus at consecutive addresses.
- Read: streams bus data out through a small credit-controlled FIFO.
- Sits between the layer-sequencing control and one `mem` bank.
- Owns the `sel`/`w_en`/address/tri-state data side of the interface that `mem` responds to.

---
 rtl/mem_bus_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/mem_bus_master.sv | 146 ++++++++++++++
 tb/tb_mem_bus_master.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types for the scratchpad bus master: FSM states, bus-cycle kinds and width defaults.
package mem_bus_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_WR,
    BUS_RD
  } bus_cyc_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and an occupancy count; push and pop may coincide.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CW-1:0]     count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] store [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign pop_data = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_bus_master.sv
// Burst initiator for one scratchpad bank: streams writes onto the bus, returns reads through a
// credit-limited FIFO so the bus never issues more reads than the FIFO can absorb.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              done,
  output logic              mem_sel,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

  localparam int LW = ADDR_W + 1;
  localparam int TW = RD_LAT + 1;
  localparam int CW = $clog2(FIFO_D + 1);

  state_t            state;
  state_t            next_state;
  bus_cyc_t          bus_cyc;
  logic [ADDR_W-1:0] cur;
  logic [LW-1:0]     remaining;
  logic [TW-1:0]     tags;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     free_slots;
  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] wdata_q;

  function automatic logic [CW-1:0] count_tags(input logic [TW-1:0] t);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < TW; i++) n = n + CW'(t[i]);
    return n;
  endfunction

  assign inflight   = count_tags(tags);
  assign free_slots = CW'(FIFO_D) - fifo_count;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // WRITE/READ linger one cycle after the last beat so the final bus cycle completes before DONE/DRAIN.
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    done       = 1'b0;
    bus_cyc    = BUS_IDLE;
    case (state)
      ST_IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid) begin
          if (cmd_len == '0)  next_state = ST_DONE;
          else if (cmd_write) next_state = ST_WRITE;
          else                next_state = ST_READ;
        end
      end
      ST_WRITE: begin
        wr_ready = (remaining != '0);
        if (remaining == '0) next_state = ST_DONE;
        else if (wr_valid)   bus_cyc = BUS_WR;
      end
      ST_READ: begin
        if (remaining == '0)            next_state = ST_DRAIN;
        else if (free_slots > inflight) bus_cyc = BUS_RD;
      end
      ST_DRAIN: begin
        if (inflight == '0) next_state = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Stage p0 -> p1: register the bus cycle and advance the burst counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_sel   <= 1'b0;
      mem_w_en  <= 1'b0;
      mem_addr  <= '0;
      cur       <= '0;
      remaining <= '0;
      tags      <= '0;
    end else begin
      mem_sel  <= (bus_cyc != BUS_IDLE);
      mem_w_en <= (bus_cyc == BUS_WR);
      tags     <= (tags << 1) | TW'(bus_cyc == BUS_RD);
      if (state == ST_IDLE && cmd_valid) begin
        cur       <= cmd_addr;
        remaining <= cmd_len;
      end else if (bus_cyc != BUS_IDLE) begin
        mem_addr  <= cur;
        cur       <= cur + ADDR_W'(1);
        remaining <= remaining - LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus_cyc == BUS_WR) wdata_q <= wr_data;
  end

  assign mem_data = (mem_sel && mem_w_en) ? wdata_q : 'z;

  // Stage p1+RD_LAT: the oldest tag marks the cycle the bank's read data is on the bus.
  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_D),
    .CW     (CW)
  ) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tags[TW-1]),
    .push_data (mem_data),
    .pop       (rd_valid && rd_ready),
    .pop_data  (fifo_head),
    .count     (fifo_count)
  );

  assign rd_valid = (fifo_count != '0);
  assign rd_data  = rd_valid ? fifo_head : '0;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master against a behavioural one-cycle-latency scratchpad bank.
module tb_mem_bus_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int RL = 1;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          done;
  logic          mem_sel;
  logic          mem_w_en;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;

  always #5 clk = ~clk;

  mem_bus_master #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .RD_LAT (RL),
    .FIFO_D (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .done      (done),
    .mem_sel   (mem_sel),
    .mem_w_en  (mem_w_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data)
  );

  // Scratchpad bank: captures writes at the bus-cycle edge, returns read data one cycle later.
  logic [DW-1:0] mem_arr [256];
  logic [DW-1:0] mem_q;
  logic          mem_drv = 1'b0;

  assign mem_data = mem_drv ? mem_q : 'z;

  always @(posedge clk) begin
    if (mem_sel && mem_w_en) mem_arr[mem_addr] <= mem_data;
    mem_q   <= mem_arr[mem_addr];
    mem_drv <= mem_sel && !mem_w_en;
  end

  int            cyc = 0;
  int            done_cnt = 0;
  logic [AW-1:0] bus_addr_q [$];
  int            bus_cyc_q [$];
  logic [DW-1:0] rd_q [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_sel) begin
      bus_addr_q.push_back(mem_addr);
      bus_cyc_q.push_back(cyc);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (!rst && rd_valid && rd_ready) rd_q.push_back(rd_data);
  end

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [AW:0] l);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input int len, input logic [DW-1:0] base);
    int n;
    send_cmd(1'b1, a, (AW + 1)'(len));
    for (int i = 0; i < len; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + DW'(i);
      n = 0;
      while (!wr_ready && n < 20) begin
        tick();
        n++;
      end
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max, output int n);
    n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    check(tag, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int b0;
    int r0;
    int d0;

    // Reset state
    repeat (3) tick();
    check("rst_cmd_ready_low", cmd_ready, 0);
    check("rst_mem_sel", mem_sel, 0);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_mem_w_en", mem_w_en, 0);
    check("post_rst_mem_addr", mem_addr, 0);
    check("post_rst_done", done, 0);
    check("post_rst_rd_valid", rd_valid, 0);
    check("post_rst_rd_data", rd_data, 0);
    check("post_rst_wr_ready", wr_ready, 0);
    check("post_rst_mem_data_z", (mem_data === {DW{1'bz}}), 1);

    // Preload 0x00..0x07 with 0x100+i
    write_burst(8'h00, 8, 32'h100);
    wait_done("preload_done", 20, n);
    tick();

    // Write 0xA0..0xA3 at 0x10
    d0 = done_cnt;
    b0 = bus_addr_q.size();
    write_burst(8'h10, 4, 32'hA0);
    wait_done("wr4_done", 20, n);
    check("wr4_done_latency", n, 1);
    tick();
    check("wr4_done_once", done_cnt - d0, 1);
    check("wr4_bus_count", bus_addr_q.size() - b0, 4);
    for (int i = 0; i < 4; i++) check("wr4_bus_addr", bus_addr_q[b0 + i], 64'h10 + i);

    // Read back 4 from 0x10, consumer always ready
    rd_ready = 1'b1;
    d0 = done_cnt;
    b0 = bus_addr_q.size();
    r0 = rd_q.size();
    send_cmd(1'b0, 8'h10, 9'd4);
    wait_done("rd4_done", 30, n);
    check("rd4_done_latency", n, 7);
    repeat (3) tick();
    check("rd4_done_once", done_cnt - d0, 1);
    check("rd4_bus_count", bus_addr_q.size() - b0, 4);
    check("rd4_bus_contiguous", bus_cyc_q[b0 + 3] - bus_cyc_q[b0], 3);
    check("rd4_rd_count", rd_q.size() - r0, 4);
    for (int i = 0; i < 4; i++) check("rd4_rd_data", rd_q[r0 + i], 64'hA0 + i);

    // Read 8 from 0x00 with consumer stalled: credit limits issue to FIFO depth
    rd_ready = 1'b0;
    d0 = done_cnt;
    b0 = bus_addr_q.size();
    r0 = rd_q.size();
    send_cmd(1'b0, 8'h00, 9'd8);
    repeat (10) tick();
    check("stall_bus_count", bus_addr_q.size() - b0, 4);
    check("stall_mem_sel_idle", mem_sel, 0);
    check("stall_rd_valid", rd_valid, 1);
    check("stall_rd_head", rd_data, 32'h100);
    check("stall_no_done", done_cnt - d0, 0);
    rd_ready = 1'b1;
    wait_done("stall_done", 40, n);
    repeat (8) tick();
    check("stall_done_once", done_cnt - d0, 1);
    check("stall_bus_total", bus_addr_q.size() - b0, 8);
    for (int i = 0; i < 8; i++) check("stall_bus_addr", bus_addr_q[b0 + i], i);
    check("stall_rd_count", rd_q.size() - r0, 8);
    for (int i = 0; i < 8; i++) check("stall_rd_data", rd_q[r0 + i], 64'h100 + i);

    // Address wrap from 0xFE
    b0 = bus_addr_q.size();
    write_burst(8'hFE, 4, 32'hB0);
    wait_done("wrap_done", 20, n);
    tick();
    check("wrap_bus_count", bus_addr_q.size() - b0, 4);
    check("wrap_addr0", bus_addr_q[b0 + 0], 8'hFE);
    check("wrap_addr1", bus_addr_q[b0 + 1], 8'hFF);
    check("wrap_addr2", bus_addr_q[b0 + 2], 8'h00);
    check("wrap_addr3", bus_addr_q[b0 + 3], 8'h01);

    // Write stream with a bubble: sel 1,0,1 and bus released in the gap
    send_cmd(1'b1, 8'h20, 9'd2);
    wr_valid = 1'b1;
    wr_data  = 32'h5A5A_0001;
    tick();
    check("bub_sel0", mem_sel, 1);
    check("bub_wen0", mem_w_en, 1);
    check("bub_data0", mem_data, 32'h5A5A_0001);
    wr_valid = 1'b0;
    tick();
    check("bub_sel1", mem_sel, 0);
    check("bub_data1_z", (mem_data === {DW{1'bz}}), 1);
    wr_valid = 1'b1;
    wr_data  = 32'h5A5A_0002;
    tick();
    wr_valid = 1'b0;
    check("bub_sel2", mem_sel, 1);
    check("bub_addr2", mem_addr, 8'h21);
    check("bub_data2", mem_data, 32'h5A5A_0002);
    wait_done("bub_done", 20, n);
    check("bub_done_latency", n, 1);
    tick();

    // Zero-length command
    d0 = done_cnt;
    b0 = bus_addr_q.size();
    send_cmd(1'b0, 8'h30, 9'd0);
    check("len0_done", done, 1);
    check("len0_sel", mem_sel, 0);
    tick();
    check("len0_done_clear", done, 0);
    check("len0_cmd_ready", cmd_ready, 1);
    check("len0_done_once", done_cnt - d0, 1);
    check("len0_no_bus", bus_addr_q.size() - b0, 0);

    // Reset after 3 of 8 read issues
    rd_ready = 1'b1;
    d0 = done_cnt;
    send_cmd(1'b0, 8'h00, 9'd8);
    repeat (3) tick();
    check("abort_sel_before", mem_sel, 1);
    check("abort_addr_before", mem_addr, 8'h02);
    rst = 1'b1;
    tick();
    check("abort_cmd_ready", cmd_ready, 0);
    check("abort_sel", mem_sel, 0);
    check("abort_wen", mem_w_en, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_rd_valid", rd_valid, 0);
    check("abort_rd_data", rd_data, 0);
    check("abort_done", done, 0);
    check("abort_wr_ready", wr_ready, 0);
    tick();
    check("abort_mem_data_z", (mem_data === {DW{1'bz}}), 1);
    rst = 1'b0;
    #1;
    check("abort_cmd_ready_after", cmd_ready, 1);
    repeat (3) tick();
    check("abort_no_done", done_cnt - d0, 0);

    r0 = rd_q.size();
    d0 = done_cnt;
    send_cmd(1'b0, 8'h10, 9'd2);
    wait_done("after_rst_done", 30, n);
    check("after_rst_done_latency", n, 5);
    repeat (3) tick();
    check("after_rst_done_once", done_cnt - d0, 1);
    check("after_rst_rd_count", rd_q.size() - r0, 2);
    check("after_rst_rd0", rd_q[r0 + 0], 32'hA0);
    check("after_rst_rd1", rd_q[r0 + 1], 32'hA1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
